// File: rtl/spdif_sample_fifo.sv
// spdif_sample_fifo
//   Stereo sample buffer in front of the spdif transmitter. The core mixer pushes
//   16-bit L/R pairs over a valid/ready handshake. The transmitter receives one pair
//   per sample_req pulse. Playback starts only after PRIME_LEVEL pairs are buffered.
//   An underrun mutes the output, counts the event and re-primes the buffer, so the
//   transmitter always sees a defined sample.
//
// Handshake: a pair is transferred on a rising clk_i edge where in_valid_i and
//   in_ready_o are both 1. in_ready_o depends only on the level register. A producer
//   that sees in_ready_o=0 holds its data until in_ready_o returns to 1.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   flush_i             synchronous flush: empty the FIFO, return to FILL, mute
//   in_valid_i/ready_o  producer handshake
//   in_l_i, in_r_i      sample pair in
//   sample_req_i        1-cycle pulse from the transmitter
//   audio_l_o/_r_o      registered sample pair out
//   level_o             occupancy, 0..2**DEPTH_LOG2
//   playing_o           1 in RUN (this is the FSM state)
//   underrun_o          saturating underrun counter
module spdif_sample_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [15:0]           in_l_i,
  input  logic [15:0]           in_r_i,
  input  logic                  sample_req_i,
  output logic [15:0]           audio_l_o,
  output logic [15:0]           audio_r_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  playing_o,
  output logic [7:0]            underrun_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   PRIME_LVL   = (DEPTH_LOG2+1)'(PRIME_LEVEL);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE     = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  push;
  logic                  pop;
  logic                  underrun;

  assign in_ready_o = (level != FULL_LEVEL);
  assign level_o    = level;
  assign playing_o  = (state == ST_RUN);

  // Flush overrides everything. Pop and underrun are judged on the registered
  // level, before this cycle's push is counted.
  assign push     = in_valid_i & in_ready_o & ~flush_i;
  assign pop      = ~flush_i & (state == ST_RUN) & sample_req_i & (level != '0);
  assign underrun = ~flush_i & (state == ST_RUN) & sample_req_i & (level == '0);

  // Storage needs no reset: the pointers and level define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {in_r_i, in_l_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      audio_l_o  <= '0;
      audio_r_o  <= '0;
      underrun_o <= '0;
    end else if (flush_i) begin
      // The underrun count is kept across a flush.
      state     <= ST_FILL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      audio_l_o <= '0;
      audio_r_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      case (state)
        ST_FILL: begin
          audio_l_o <= '0;
          audio_r_o <= '0;
          // Uses the registered level, so RUN starts the cycle after the
          // priming push.
          if (level >= PRIME_LVL) state <= ST_RUN;
        end
        ST_RUN: begin
          if (pop) begin
            audio_l_o <= mem[rd_ptr][15:0];
            audio_r_o <= mem[rd_ptr][31:16];
          end else if (underrun) begin
            audio_l_o <= '0;
            audio_r_o <= '0;
            state     <= ST_FILL;
            if (underrun_o != 8'hFF) underrun_o <= underrun_o + 8'd1;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_spdif_sample_fifo.sv
module tb_spdif_sample_fifo;

  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic        sample_req;
  logic [15:0] audio_l;
  logic [15:0] audio_r;
  logic [4:0]  level;
  logic        playing;
  logic [7:0]  underrun;

  spdif_sample_fifo #(.DEPTH_LOG2(4), .PRIME_LEVEL(PRIME)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_l_i       (in_l),
    .in_r_i       (in_r),
    .sample_req_i (sample_req),
    .audio_l_o    (audio_l),
    .audio_r_o    (audio_r),
    .level_o      (level),
    .playing_o    (playing),
    .underrun_o   (underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference state
  logic [31:0] exp_q[$];
  logic        m_run;
  int          m_und;
  logic [31:0] m_audio;
  logic [15:0] data_k;
  int          tests;
  int          failed;

  typedef struct {
    logic       v;
    logic       q;
    logic       f;
    logic [4:0] exp_level;
    logic       exp_play;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic v, logic q, logic f, logic [4:0] l, logic p, logic r);
    vec_t t;
    t.v = v; t.q = q; t.f = f; t.exp_level = l; t.exp_play = p; t.exp_ready = r;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run   = 1'b0;
    m_und   = 0;
    m_audio = '0;
    data_k  = '0;
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the rising edge
  // and outputs are compared at the same point after the next edge.
  task automatic cycle(input logic v, input logic q, input logic f);
    logic [31:0] d;
    int          lvl;
    logic        rdy_exp;
    logic        do_push;
    logic        do_pop;
    logic        do_und;
    d = {16'hABCD - data_k, 16'h1234 + data_k};
    in_valid   = v;
    in_l       = d[15:0];
    in_r       = d[31:16];
    sample_req = q;
    flush      = f;
    lvl     = exp_q.size();
    rdy_exp = (lvl != DEPTH);
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    do_push = v && rdy_exp && !f;
    do_pop  = q && !f && m_run && (lvl != 0);
    do_und  = q && !f && m_run && (lvl == 0);
    if (do_push) begin
      exp_q.push_back(d);
      data_k = data_k + 16'd1;
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    sample_req = 1'b0;
    flush      = 1'b0;
    if (f) begin
      exp_q.delete();
      m_run   = 1'b0;
      m_audio = '0;
    end else if (!m_run) begin
      m_audio = '0;
      if (lvl >= PRIME) m_run = 1'b1;
    end else if (do_pop) begin
      m_audio = exp_q.pop_front();
    end else if (do_und) begin
      m_audio = '0;
      m_run   = 1'b0;
      if (m_und < 255) m_und++;
    end
    check("level",    32'(level),    32'(exp_q.size()));
    check("playing",  32'(playing),  32'(m_run));
    check("audio_l",  32'(audio_l),  32'(m_audio[15:0]));
    check("audio_r",  32'(audio_r),  32'(m_audio[31:16]));
    check("underrun", 32'(underrun), 32'(m_und));
  endtask

  task automatic prime_and_run();
    repeat (PRIME) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_and_underrun();
    while (exp_q.size() != 0) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_l = '0;
    in_r = '0;
    sample_req = 1'b0;
    model_reset();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    32'(in_ready), 32'd1);
    check("rst_level",    32'(level),    32'd0);
    check("rst_playing",  32'(playing),  32'd0);
    check("rst_audio",    32'({audio_r, audio_l}), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    // Test 1/2: seven pushes, ignored reqs in FILL, eighth push, RUN, first pop
    for (int i = 0; i < 7; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 5'(i + 1), 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].v, vecs[i].q, vecs[i].f);
      check("vec_level",   32'(level),    32'(vecs[i].exp_level));
      check("vec_playing", 32'(playing),  32'(vecs[i].exp_play));
      check("vec_ready",   32'(in_ready), 32'(vecs[i].exp_ready));
    end
    check("first_pop_l", 32'(audio_l), 32'h1234);
    check("first_pop_r", 32'(audio_r), 32'hABCD);

    // Test 3: fill to 16, hold valid, req+push at full, then push+pop mid-level
    repeat (9) cycle(1'b1, 1'b0, 1'b0);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(level),    32'd16);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("full_pop_level", 32'(level),    32'd15);
    check("full_pop_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("pushpop_level", 32'(level), 32'd15);

    // Test 4: drain, underrun, then saturate the counter
    cycle(1'b0, 1'b0, 1'b0);
    drain_and_underrun();
    check("und_count", 32'(underrun), 32'd1);
    check("und_play",  32'(playing),  32'd0);
    check("und_audio", 32'({audio_r, audio_l}), 32'd0);
    for (int n = 0; n < 300; n++) begin
      prime_and_run();
      drain_and_underrun();
    end
    check("und_saturate", 32'(underrun), 32'd255);

    // Test 5: flush together with push and req in RUN
    prime_and_run();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("flush_level", 32'(level),    32'd0);
    check("flush_play",  32'(playing),  32'd0);
    check("flush_audio", 32'({audio_r, audio_l}), 32'd0);
    check("flush_und",   32'(underrun), 32'd255);
    cycle(1'b0, 1'b0, 1'b0);
    check("flush_empty", 32'(level), 32'd0);

    // Test 6: asynchronous reset mid-stream at level 5 in RUN
    prime_and_run();
    repeat (3) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("pre_rst_level", 32'(level),   32'd5);
    check("pre_rst_play",  32'(playing), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready",    32'(in_ready), 32'd1);
    check("arst_level",    32'(level),    32'd0);
    check("arst_playing",  32'(playing),  32'd0);
    check("arst_audio",    32'({audio_r, audio_l}), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    data_k = 16'h0100;
    prime_and_run();
    cycle(1'b0, 1'b1, 1'b0);
    check("post_rst_l", 32'(audio_l), 32'(16'h1234 + 16'h0100));
    check("post_rst_r", 32'(audio_r), 32'(16'hABCD - 16'h0100));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
